lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Responder end of the 8080-style parallel LCD write bus (wr/cs/dc/24-bit data) driven by the display controller.
- Decodes the command/parameter stream and tracks the column/page address window (0x2A/0x2B).
- Converts 0x2C memory-write data into addressed pixel writes (x, y, data) for a framebuffer, scan-out or checker downstream.
- Runs on the same clk as the bus driver; used as the on-chip panel emulator and as the protocol monitor in system benches.

Parameters:
- H_RES, 800, panel width; default column window 0..H_RES-1.
- V_RES, 480, panel height; default page window 0..V_RES-1.
- PIX_W, 24, pixel data width taken from lcd_data[PIX_W-1:0].

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- lcd_rst_n  in  1  panel reset from controller, active-low; acts as a synchronous soft reset.
- lcd_cs  in  1  chip select, active-low.
- lcd_wr  in  1  write strobe; word accepted on rising edge.
- lcd_dc  in  1  0 = command, 1 = parameter/data.
- lcd_data  in  24  bus data; commands and parameters use [7:0].
- pix_valid  out  1  one-cycle pulse: pixel write.
- pix_x  out  16  pixel column.
- pix_y  out  16  pixel row.
- pix_data  out  PIX_W  pixel value.
- frame_done  out  1  one-cycle pulse, coincident with the last pixel of the window.
- cmd_valid  out  1  one-cycle pulse per command word.
- cmd_code  out  8  last command code.
- display_on  out  1  set by 0x29, cleared by 0x28 or 0x01.
- proto_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Input registers: lcd_wr, lcd_cs, lcd_dc and lcd_data are registered twice (q1, q2).
- Write event: q1.wr=1 && q2.wr=0 && q2.cs=0; the event captures q2.dc and q2.data.
  - Bus minimum: wr low ≥1 clk and high ≥1 clk; data stable while wr is low.
  - wr edges while cs is high are ignored.
- Output latency: every output is registered and asserts exactly 1 clk after the write-event cycle.
- Reset (rst low, or lcd_rst_n low sampled high-priority) forces:
  - all pulses 0, cmd_code 0x00, display_on 0, pix_x/pix_y/pix_data 0;
  - window SC=0, EC=H_RES-1, SP=0, EP=V_RES-1;
  - state IDLE.
- States: IDLE, COL_PARAM, PAGE_PARAM, MEMWR, IGNORE.
- Any command word (dc=0):
  - pulses cmd_valid and loads cmd_code;
  - aborts the current state; if the previous state was COL_PARAM/PAGE_PARAM with fewer than 4 params received, also pulses proto_err and leaves the window unchanged.
  - Next state by code:
    - 0x2A → COL_PARAM, param index 0.
    - 0x2B → PAGE_PARAM, param index 0.
    - 0x2C → MEMWR; x=SC, y=SP.
    - 0x29 → display_on=1, IDLE.
    - 0x28 → display_on=0, IDLE.
    - 0x01 → window reset to default, display_on=0, IDLE.
    - any other code → IGNORE.
- COL_PARAM / PAGE_PARAM:
  - Params arrive big-endian: start_hi, start_lo, end_hi, end_lo.
  - The 4th param commits the window, then IDLE.
  - Commit is rejected (window kept, proto_err pulse) if start>end, or end≥H_RES (column) / end≥V_RES (page).
- MEMWR, each data word:
  - pix_valid=1 with pix_x=x, pix_y=y, pix_data=data[PIX_W-1:0].
  - Address advance: x<EC → x+1. x==EC → x=SC and y+1. x==EC && y==EP → x=SC, y=SP, and frame_done pulses with that pixel.
  - Writes continue indefinitely (wrap-around).
- IGNORE, or data in IDLE: words discarded silently; no pulses.
- Single-pixel window (SC==EC, SP==EP): every pixel pulses frame_done.
- Window commands issued mid-MEMWR take effect only at the next 0x2C.

Optional Feature:
- Macro LCD_RX_STATS_EN. When defined, adds outputs:
  - stat_frames[15:0]: count of frame_done pulses;
  - stat_pixels[31:0]: count of pix_valid pulses, cleared on each frame_done;
  - stat_unknown[7:0]: count of commands sent to IGNORE.
  - All counters saturate; all are cleared by either reset.
- When undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Window set and fill: 0x2A 00 00 00 03, 0x2B 00 00 00 01, 0x2C, then 8 data words 0x000001..0x000008.
  → pix (0,0)..(3,0),(0,1)..(3,1); frame_done with the 8th pixel; a 9th word lands at (0,0).
- Defaults after reset: 0x2C, then 800 words.
  → last pixel at (799,0); next at (0,1); no frame_done.
- Truncated parameters: 0x2A 00 10, then 0x2C.
  → proto_err pulse on 0x2C; first pixel at (0,0), window unchanged.
- Bad window: 0x2A 00 05 00 02.
  → proto_err; 0x2C pixel at old SC.
  - Also: 0x2B 01 00 01 F0 (end 496 ≥ 480) → rejected.
- Mode commands and filtering: 0x29 → display_on=1; 0xB0 + 7 params → cmd_valid once, no pix_valid; 0x28 → display_on=0.
  - lcd_cs=1 during 10 wr toggles → no events.
- Reset mid-stream: lcd_rst_n low during MEMWR at pixel (3,2).
  → all outputs at reset values, window default.
  - Async rst low mid-frame → same.
  - Data after release without 0x2C → no pix_valid.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder end of an 8080-style parallel LCD write bus.
// Decodes the command/parameter stream, tracks the column/page address
// window (0x2A/0x2B) and turns 0x2C memory-write data into addressed pixel
// writes (x, y, data) for a downstream framebuffer, scan-out or checker.
//
// Optional build macro: LCD_RX_STATS_EN adds saturating frame/pixel/unknown
// command counters as extra outputs. Without it the core is unchanged.
//
// Bus handshake: there is no back-pressure. A word is transferred when
// lcd_wr rises while lcd_cs is low; the controller holds lcd_dc/lcd_data
// stable while lcd_wr is low and keeps lcd_wr low and high for at least one
// clk each. Every output is registered and reacts one clk after the cycle in
// which the (double-registered) rising edge is seen.
module lcd_bus_receiver #(
    parameter int H_RES = 800,
    parameter int V_RES = 480,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lcd_rst_n,
    input  logic             lcd_cs,
    input  logic             lcd_wr,
    input  logic             lcd_dc,
    input  logic [23:0]      lcd_data,
    output logic             pix_valid,
    output logic [15:0]      pix_x,
    output logic [15:0]      pix_y,
    output logic [PIX_W-1:0] pix_data,
    output logic             frame_done,
    output logic             cmd_valid,
    output logic [7:0]       cmd_code,
    output logic             display_on,
    output logic             proto_err
`ifdef LCD_RX_STATS_EN
    ,
    output logic [15:0]      stat_frames,
    output logic [31:0]      stat_pixels,
    output logic [7:0]       stat_unknown
`endif
);

    localparam logic [15:0] COL_MAX  = 16'(H_RES - 1);
    localparam logic [15:0] PAGE_MAX = 16'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COL_PARAM,
        S_PAGE_PARAM,
        S_MEMWR,
        S_IGNORE
    } state_t;

    // Bus sampling pipeline
    logic        q1_wr, q1_cs, q1_dc;
    logic [23:0] q1_data;
    logic        q2_wr, q2_cs, q2_dc;
    logic [23:0] q2_data;
    logic        wr_event;

    // Decoder state
    state_t      state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [7:0]  par0_q, par0_d, par1_q, par1_d, par2_q, par2_d;

    // Programmed window and the window latched by the last 0x2C
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] asc_q, asc_d, aec_q, aec_d, asp_q, asp_d, aep_q, aep_d;
    logic [15:0] x_q, x_d, y_q, y_d;

    // Next values of the registered outputs
    logic             pix_valid_d, frame_done_d, cmd_valid_d, proto_err_d;
    logic [15:0]      pix_x_d, pix_y_d;
    logic [PIX_W-1:0] pix_data_d;
    logic [7:0]       cmd_code_d;
    logic             display_on_d;
    logic             ignore_cmd;

    // Window parameter candidate assembled from the three stored bytes
    logic [15:0] p_start, p_end, p_limit;

    assign wr_event = q1_wr & ~q2_wr & ~q2_cs;
    assign p_start  = {par0_q, par1_q};
    assign p_end    = {par2_q, q2_data[7:0]};
    assign p_limit  = (state_q == S_COL_PARAM) ? COL_MAX : PAGE_MAX;

    // Double-register the asynchronous bus; idle levels keep wr/cs high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1_wr   <= 1'b1;
            q1_cs   <= 1'b1;
            q1_dc   <= 1'b0;
            q1_data <= '0;
            q2_wr   <= 1'b1;
            q2_cs   <= 1'b1;
            q2_dc   <= 1'b0;
            q2_data <= '0;
        end else begin
            q1_wr   <= lcd_wr;
            q1_cs   <= lcd_cs;
            q1_dc   <= lcd_dc;
            q1_data <= lcd_data;
            q2_wr   <= q1_wr;
            q2_cs   <= q1_cs;
            q2_dc   <= q1_dc;
            q2_data <= q1_data;
        end
    end

    // Next-state and output decode for one captured bus word
    always_comb begin
        state_d      = state_q;
        pidx_d       = pidx_q;
        par0_d       = par0_q;
        par1_d       = par1_q;
        par2_d       = par2_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        asc_d        = asc_q;
        aec_d        = aec_q;
        asp_d        = asp_q;
        aep_d        = aep_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        cmd_valid_d  = 1'b0;
        proto_err_d  = 1'b0;
        pix_x_d      = pix_x;
        pix_y_d      = pix_y;
        pix_data_d   = pix_data;
        cmd_code_d   = cmd_code;
        display_on_d = display_on;
        ignore_cmd   = 1'b0;

        if (!lcd_rst_n) begin
            // Panel soft reset: same effect as the system reset
            state_d      = S_IDLE;
            pidx_d       = 2'd0;
            par0_d       = 8'h00;
            par1_d       = 8'h00;
            par2_d       = 8'h00;
            sc_d         = 16'd0;
            ec_d         = COL_MAX;
            sp_d         = 16'd0;
            ep_d         = PAGE_MAX;
            asc_d        = 16'd0;
            aec_d        = COL_MAX;
            asp_d        = 16'd0;
            aep_d        = PAGE_MAX;
            x_d          = 16'd0;
            y_d          = 16'd0;
            pix_x_d      = 16'd0;
            pix_y_d      = 16'd0;
            pix_data_d   = '0;
            cmd_code_d   = 8'h00;
            display_on_d = 1'b0;
        end else if (wr_event) begin
            if (!q2_dc) begin
                // Command word: always aborts whatever was in progress
                cmd_valid_d = 1'b1;
                cmd_code_d  = q2_data[7:0];
                pidx_d      = 2'd0;
                if (state_q == S_COL_PARAM || state_q == S_PAGE_PARAM)
                    proto_err_d = 1'b1;
                case (q2_data[7:0])
                    8'h2A: state_d = S_COL_PARAM;
                    8'h2B: state_d = S_PAGE_PARAM;
                    8'h2C: begin
                        state_d = S_MEMWR;
                        asc_d   = sc_q;
                        aec_d   = ec_q;
                        asp_d   = sp_q;
                        aep_d   = ep_q;
                        x_d     = sc_q;
                        y_d     = sp_q;
                    end
                    8'h29: begin
                        state_d      = S_IDLE;
                        display_on_d = 1'b1;
                    end
                    8'h28: begin
                        state_d      = S_IDLE;
                        display_on_d = 1'b0;
                    end
                    8'h01: begin
                        state_d      = S_IDLE;
                        display_on_d = 1'b0;
                        sc_d         = 16'd0;
                        ec_d         = COL_MAX;
                        sp_d         = 16'd0;
                        ep_d         = PAGE_MAX;
                    end
                    default: begin
                        state_d    = S_IGNORE;
                        ignore_cmd = 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    S_COL_PARAM, S_PAGE_PARAM: begin
                        if (pidx_q != 2'd3) begin
                            case (pidx_q)
                                2'd0:    par0_d = q2_data[7:0];
                                2'd1:    par1_d = q2_data[7:0];
                                default: par2_d = q2_data[7:0];
                            endcase
                            pidx_d = pidx_q + 2'd1;
                        end else begin
                            // Fourth byte: commit only a well-formed window
                            state_d = S_IDLE;
                            pidx_d  = 2'd0;
                            if (p_start > p_end || p_end > p_limit) begin
                                proto_err_d = 1'b1;
                            end else if (state_q == S_COL_PARAM) begin
                                sc_d = p_start;
                                ec_d = p_end;
                            end else begin
                                sp_d = p_start;
                                ep_d = p_end;
                            end
                        end
                    end
                    S_MEMWR: begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        pix_data_d  = q2_data[PIX_W-1:0];
                        if (x_q != aec_q) begin
                            x_d = x_q + 16'd1;
                        end else begin
                            x_d = asc_q;
                            if (y_q != aep_q) begin
                                y_d = y_q + 16'd1;
                            end else begin
                                y_d          = asp_q;
                                frame_done_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, window and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pidx_q     <= 2'd0;
            par0_q     <= 8'h00;
            par1_q     <= 8'h00;
            par2_q     <= 8'h00;
            sc_q       <= 16'd0;
            ec_q       <= COL_MAX;
            sp_q       <= 16'd0;
            ep_q       <= PAGE_MAX;
            asc_q      <= 16'd0;
            aec_q      <= COL_MAX;
            asp_q      <= 16'd0;
            aep_q      <= PAGE_MAX;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            cmd_valid  <= 1'b0;
            proto_err  <= 1'b0;
            pix_x      <= 16'd0;
            pix_y      <= 16'd0;
            pix_data   <= '0;
            cmd_code   <= 8'h00;
            display_on <= 1'b0;
        end else begin
            state_q    <= state_d;
            pidx_q     <= pidx_d;
            par0_q     <= par0_d;
            par1_q     <= par1_d;
            par2_q     <= par2_d;
            sc_q       <= sc_d;
            ec_q       <= ec_d;
            sp_q       <= sp_d;
            ep_q       <= ep_d;
            asc_q      <= asc_d;
            aec_q      <= aec_d;
            asp_q      <= asp_d;
            aep_q      <= aep_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pix_valid  <= pix_valid_d;
            frame_done <= frame_done_d;
            cmd_valid  <= cmd_valid_d;
            proto_err  <= proto_err_d;
            pix_x      <= pix_x_d;
            pix_y      <= pix_y_d;
            pix_data   <= pix_data_d;
            cmd_code   <= cmd_code_d;
            display_on <= display_on_d;
        end
    end

`ifdef LCD_RX_STATS_EN
    // Saturating activity counters, aligned with the pulses they count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_frames  <= '0;
            stat_pixels  <= '0;
            stat_unknown <= '0;
        end else if (!lcd_rst_n) begin
            stat_frames  <= '0;
            stat_pixels  <= '0;
            stat_unknown <= '0;
        end else begin
            if (frame_done_d && stat_frames != 16'hFFFF)
                stat_frames <= stat_frames + 16'd1;
            if (frame_done_d)
                stat_pixels <= '0;
            else if (pix_valid_d && stat_pixels != 32'hFFFF_FFFF)
                stat_pixels <= stat_pixels + 32'd1;
            if (ignore_cmd && stat_unknown != 8'hFF)
                stat_unknown <= stat_unknown + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: a window/index model predicts every
// output pulse, a compare process checks each cycle, and literal checks pin
// the key positions from the test plan.
`timescale 1ns/1ps
module tb_lcd_bus_receiver;
    localparam int H_RES = 800;
    localparam int V_RES = 480;
    localparam int PIX_W = 24;

    logic        clk = 1'b0;
    logic        rst, lcd_rst_n, lcd_cs, lcd_wr, lcd_dc;
    logic [23:0] lcd_data;
    logic        pix_valid, frame_done, cmd_valid, display_on, proto_err;
    logic [15:0] pix_x, pix_y;
    logic [PIX_W-1:0] pix_data;
    logic [7:0]  cmd_code;
`ifdef LCD_RX_STATS_EN
    logic [15:0] stat_frames;
    logic [31:0] stat_pixels;
    logic [7:0]  stat_unknown;
`endif

    lcd_bus_receiver #(.H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .lcd_rst_n(lcd_rst_n), .lcd_cs(lcd_cs),
        .lcd_wr(lcd_wr), .lcd_dc(lcd_dc), .lcd_data(lcd_data),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_done(frame_done), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .display_on(display_on), .proto_err(proto_err)
`ifdef LCD_RX_STATS_EN
        , .stat_frames(stat_frames), .stat_pixels(stat_pixels),
        .stat_unknown(stat_unknown)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pv, fd, cv, pe;
        logic [15:0] x, y;
        logic [23:0] d;
        logic [7:0]  code;
        logic        disp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   n_pv = 0, n_fd = 0, n_cv = 0, n_pe = 0;
    logic chk_en = 1'b0;
    logic [7:0] chk_code = 8'h00;
    logic chk_disp = 1'b0;

    // Reference model: decoder mode, window, and a linear index in the frame
    localparam int M_IDLE = 0, M_COL = 1, M_PAGE = 2, M_MEM = 3, M_IGN = 4;
    int   m_mode, m_sc, m_ec, m_sp, m_ep, m_asc, m_asp, m_w, m_h, m_idx, m_np;
    int   m_par[4];
    logic m_disp;
    logic [7:0] m_code;

    function automatic void model_reset();
        m_mode = M_IDLE; m_np = 0; m_idx = 0;
        m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1;
        m_asc = 0; m_asp = 0; m_w = H_RES; m_h = V_RES;
        m_disp = 1'b0; m_code = 8'h00;
    endfunction

    function automatic void model_write(input logic dc, input logic [23:0] d);
        exp_t e;
        int s, en, lim;
        e = '0;
        if (!dc) begin
            e.cv = 1'b1;
            e.pe = (m_mode == M_COL || m_mode == M_PAGE);
            m_code = d[7:0];
            m_np = 0;
            case (d[7:0])
                8'h2A: m_mode = M_COL;
                8'h2B: m_mode = M_PAGE;
                8'h2C: begin
                    m_mode = M_MEM; m_asc = m_sc; m_asp = m_sp;
                    m_w = m_ec - m_sc + 1; m_h = m_ep - m_sp + 1; m_idx = 0;
                end
                8'h29: begin m_mode = M_IDLE; m_disp = 1'b1; end
                8'h28: begin m_mode = M_IDLE; m_disp = 1'b0; end
                8'h01: begin
                    m_mode = M_IDLE; m_disp = 1'b0;
                    m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1;
                end
                default: m_mode = M_IGN;
            endcase
            e.code = m_code; e.disp = m_disp;
            exp_q.push_back(e);
        end else if (m_mode == M_COL || m_mode == M_PAGE) begin
            m_par[m_np] = int'(d[7:0]);
            m_np++;
            if (m_np == 4) begin
                s   = m_par[0] * 256 + m_par[1];
                en  = m_par[2] * 256 + m_par[3];
                lim = (m_mode == M_COL) ? H_RES : V_RES;
                if (s > en || en >= lim) begin
                    e.pe = 1'b1; e.code = m_code; e.disp = m_disp;
                    exp_q.push_back(e);
                end else if (m_mode == M_COL) begin
                    m_sc = s; m_ec = en;
                end else begin
                    m_sp = s; m_ep = en;
                end
                m_mode = M_IDLE; m_np = 0;
            end
        end else if (m_mode == M_MEM) begin
            e.pv = 1'b1;
            e.x = 16'(m_asc + m_idx % m_w);
            e.y = 16'(m_asp + m_idx / m_w);
            e.d = d;
            e.fd = (m_idx == m_w * m_h - 1);
            e.code = m_code; e.disp = m_disp;
            m_idx = (m_idx + 1) % (m_w * m_h);
            exp_q.push_back(e);
        end
    endfunction

    // Scoreboard: every pulse cycle pops one prediction; status checked each cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst || !lcd_rst_n) begin
            chk_code = 8'h00;
            chk_disp = 1'b0;
        end
        if (pix_valid)  n_pv++;
        if (frame_done) n_fd++;
        if (cmd_valid)  n_cv++;
        if (proto_err)  n_pe++;
        if (chk_en) begin
            if (pix_valid || frame_done || cmd_valid || proto_err) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got pv/fd/cv/pe=%b%b%b%b expected none",
                             pix_valid, frame_done, cmd_valid, proto_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({pix_valid, frame_done, cmd_valid, proto_err} !== {e.pv, e.fd, e.cv, e.pe}) begin
                        n_err++;
                        $display("FAIL pulses: got pv/fd/cv/pe=%b%b%b%b expected %b%b%b%b",
                                 pix_valid, frame_done, cmd_valid, proto_err, e.pv, e.fd, e.cv, e.pe);
                    end
                    if (e.pv) begin
                        n_checks++;
                        if (pix_x !== e.x || pix_y !== e.y || pix_data !== e.d) begin
                            n_err++;
                            $display("FAIL pixel: got (%0d,%0d)=%h expected (%0d,%0d)=%h",
                                     pix_x, pix_y, pix_data, e.x, e.y, e.d);
                        end
                    end
                    chk_code = e.code;
                    chk_disp = e.disp;
                end
            end
            n_checks++;
            if (cmd_code !== chk_code || display_on !== chk_disp) begin
                n_err++;
                $display("FAIL status: got code=%h disp=%b expected code=%h disp=%b",
                         cmd_code, display_on, chk_code, chk_disp);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_lit({tag, "_pulses"}, {28'd0, pix_valid, frame_done, cmd_valid, proto_err}, 32'd0);
        check_lit({tag, "_pix_x"}, {16'd0, pix_x}, 32'd0);
        check_lit({tag, "_pix_y"}, {16'd0, pix_y}, 32'd0);
        check_lit({tag, "_pix_data"}, {8'd0, pix_data}, 32'd0);
        check_lit({tag, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
        check_lit({tag, "_display_on"}, {31'd0, display_on}, 32'd0);
    endtask

    // Driver: one bus word, wr low 2 clk then high 3 clk
    task automatic bus_write(input logic dc, input logic [23:0] d);
        model_write(dc, d);
        @(posedge clk); #1;
        lcd_dc = dc; lcd_data = d; lcd_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 lcd_wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_pulse: got %0d predictions left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic cmd(input logic [7:0] c);
        bus_write(1'b0, {16'd0, c});
    endtask

    task automatic par(input logic [7:0] p);
        bus_write(1'b1, {16'd0, p});
    endtask

    task automatic soft_reset();
        chk_en = 1'b0;
        @(posedge clk); #1 lcd_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("soft_rst");
        lcd_rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        @(posedge clk); #1 chk_en = 1'b1;
    endtask

    initial begin
        int fd_before, cv_before, pv_before;
        // Reset
        rst = 1'b0; lcd_rst_n = 1'b1; lcd_cs = 1'b1; lcd_wr = 1'b1;
        lcd_dc = 1'b0; lcd_data = 24'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        rst = 1'b1; lcd_cs = 1'b0;
        @(posedge clk); #1 chk_en = 1'b1;

        // Window set and fill: 4x2 window
        cmd(8'h2A); par(8'h00); par(8'h00); par(8'h00); par(8'h03);
        cmd(8'h2B); par(8'h00); par(8'h00); par(8'h00); par(8'h01);
        cmd(8'h2C);
        for (int i = 1; i <= 8; i++) bus_write(1'b1, 24'(i));
        check_lit("fill_last_x", {16'd0, pix_x}, 32'd3);
        check_lit("fill_last_y", {16'd0, pix_y}, 32'd1);
        check_lit("fill_last_data", {8'd0, pix_data}, 32'd8);
        check_lit("fill_frame_done", n_fd, 32'd1);
        bus_write(1'b1, 24'h000009);
        check_lit("fill_wrap_xy", {pix_x, pix_y}, 32'd0);

        // Default window: 800 pixels fill row 0
        soft_reset();
        cmd(8'h2C);
        for (int i = 0; i < 800; i++) bus_write(1'b1, 24'($urandom_range(0, 24'hFFFFFF)));
        check_lit("dflt_last_xy", {pix_x, pix_y}, {16'd799, 16'd0});
        bus_write(1'b1, 24'hABCDEF);
        check_lit("dflt_next_xy", {pix_x, pix_y}, {16'd0, 16'd1});
        check_lit("dflt_no_frame", n_fd, 32'd1);

        // Truncated parameters
        cmd(8'h2A); par(8'h00); par(8'h10);
        cmd(8'h2C);
        check_lit("trunc_proto", n_pe, 32'd1);
        bus_write(1'b1, 24'h123456);
        check_lit("trunc_first_xy", {pix_x, pix_y}, 32'd0);

        // Bad windows are rejected
        cmd(8'h2A); par(8'h00); par(8'h04); par(8'h00); par(8'h09);
        cmd(8'h2A); par(8'h00); par(8'h05); par(8'h00); par(8'h02);
        check_lit("bad_col_proto", n_pe, 32'd2);
        cmd(8'h2C); bus_write(1'b1, 24'h00AA55);
        check_lit("bad_col_x", {16'd0, pix_x}, 32'd4);
        cmd(8'h2B); par(8'h01); par(8'h00); par(8'h01); par(8'hF0);
        check_lit("bad_page_proto", n_pe, 32'd3);
        cmd(8'h2C); bus_write(1'b1, 24'h0055AA);
        check_lit("bad_page_xy", {pix_x, pix_y}, {16'd4, 16'd0});

        // Mode commands and filtering
        cmd(8'h29);
        check_lit("disp_on", {31'd0, display_on}, 32'd1);
        cv_before = n_cv; pv_before = n_pv;
        cmd(8'hB0);
        for (int i = 0; i < 7; i++) par(8'(i + 1));
        check_lit("ignore_one_cmd", n_cv, 32'(cv_before + 1));
        check_lit("ignore_no_pix", n_pv, 32'(pv_before));
        cmd(8'h28);
        check_lit("disp_off", {24'd0, cmd_code}, 32'h28);
        check_lit("disp_off_flag", {31'd0, display_on}, 32'd0);

        // Strobes with cs high are invisible
        cv_before = n_cv;
        @(posedge clk); #1 lcd_cs = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lcd_dc = i[0]; lcd_data = 24'h2C; lcd_wr = 1'b0;
            repeat (2) @(posedge clk);
            #1 lcd_wr = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1 lcd_cs = 1'b0;
        check_lit("cs_high_no_cmd", n_cv, 32'(cv_before));

        // Software reset command restores the default window
        cmd(8'h2A); par(8'h00); par(8'h00); par(8'h00); par(8'h01);
        cmd(8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) bus_write(1'b1, 24'(i));
        check_lit("swreset_x", {16'd0, pix_x}, 32'd2);

        // Soft reset mid-stream at pixel (3,2)
        cmd(8'h2A); par(8'h00); par(8'h00); par(8'h00); par(8'h03);
        cmd(8'h2B); par(8'h00); par(8'h00); par(8'h00); par(8'h03);
        cmd(8'h2C);
        for (int i = 0; i < 12; i++) bus_write(1'b1, 24'(i + 16'h100));
        check_lit("mid_xy", {pix_x, pix_y}, {16'd3, 16'd2});
        soft_reset();
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) bus_write(1'b1, 24'(i));
        check_lit("after_soft_xy", {pix_x, pix_y}, {16'd4, 16'd0});

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) bus_write(1'b1, 24'(i + 7));
        chk_en = 1'b0;
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("async_rst");
        rst = 1'b1;
        model_reset();
        exp_q.delete();
        @(posedge clk); #1 chk_en = 1'b1;
        pv_before = n_pv;
        for (int i = 0; i < 3; i++) bus_write(1'b1, 24'(i + 40));
        check_lit("no_memwr_no_pix", n_pv, 32'(pv_before));

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
